// File: rtl/manchester_frame_rx.sv
// Manchester frame receiver: edge-interval bit recovery, preamble lock, and a
// FRAME_BYTES payload captured into a shadow buffer that is committed atomically.
module manchester_frame_rx #(
    parameter int          HALF_BIT_CYCLES = 8,
    parameter logic [7:0]  PREAMBLE        = 8'hAA,
    parameter int          FRAME_BYTES     = 4,
    parameter int          ADDR_W          = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              serial_in,
    input  logic [ADDR_W-1:0] address,
    output logic [7:0]        read_data,
    output logic              frame_valid,
    output logic              frame_start,
    output logic              bit_strobe,
    output logic              bit_data,
    output logic              error
);

    localparam int H     = HALF_BIT_CYCLES;
    localparam int SAT   = 3 * H;
    localparam int CNT_W = $clog2(SAT + 1);

    localparam logic [CNT_W-1:0] SHORT_MIN = CNT_W'(H / 2);
    localparam logic [CNT_W-1:0] LONG_MIN  = CNT_W'((3 * H) / 2);
    localparam logic [CNT_W-1:0] SAT_VAL   = CNT_W'(SAT);
    localparam logic [CNT_W-1:0] TMO_PRE   = CNT_W'(SAT - 1);

    typedef enum logic [1:0] {IDLE, HUNT, PAYLOAD} state_t;

    state_t state, state_nx;

    logic              sync_p0, sync_p1, line_p2;
    logic [CNT_W-1:0]  interval;
    logic              phase_mid;
    logic [7:0]        shift_reg;
    logic [2:0]        bit_pos;
    logic [ADDR_W-1:0] byte_idx;
    logic [7:0]        shadow    [FRAME_BYTES];
    logic [7:0]        committed [FRAME_BYTES];
    logic              commit_pend;
    logic              start_q, strobe_q, bit_q, error_q;

    logic       edge_seen, in_short, in_long, mid_edge, bound_edge, timeout, fault, last_bit;
    logic [7:0] shifted;
    logic       take_shift, clear_shift, do_lock, take_bit, do_abort;

    // Edge classification against the interval since the previous edge
    always_comb begin
        edge_seen  = sync_p1 ^ line_p2;
        in_short   = (interval >= SHORT_MIN) && (interval < LONG_MIN);
        in_long    = (interval >= LONG_MIN) && (interval < SAT_VAL);
        mid_edge   = edge_seen && ((in_short && !phase_mid) || (in_long && phase_mid));
        bound_edge = edge_seen && in_short && phase_mid;
        timeout    = !edge_seen && (interval == TMO_PRE);
        fault      = timeout || (edge_seen && !mid_edge && !bound_edge);
        shifted    = {shift_reg[6:0], sync_p1};
        last_bit   = (bit_pos == 3'd7) && (byte_idx == ADDR_W'(FRAME_BYTES - 1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else if (enable) begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (edge_seen) state_nx = HUNT;
            HUNT: begin
                if (fault)                                  state_nx = IDLE;
                else if (mid_edge && (shifted == PREAMBLE)) state_nx = PAYLOAD;
            end
            PAYLOAD: begin
                if (fault)                     state_nx = IDLE;
                else if (mid_edge && last_bit) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        take_shift  = 1'b0;
        clear_shift = 1'b0;
        do_lock     = 1'b0;
        take_bit    = 1'b0;
        do_abort    = 1'b0;
        unique case (state)
            IDLE: take_shift = edge_seen;
            HUNT: begin
                if (fault) begin
                    clear_shift = 1'b1;
                end else if (mid_edge) begin
                    take_shift = 1'b1;
                    do_lock    = (shifted == PREAMBLE);
                end
            end
            PAYLOAD: begin
                if (fault) begin
                    do_abort    = 1'b1;
                    clear_shift = 1'b1;
                end else if (mid_edge) begin
                    take_bit    = 1'b1;
                    clear_shift = last_bit;
                end
            end
            default: clear_shift = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_p0     <= 1'b0;
            sync_p1     <= 1'b0;
            line_p2     <= 1'b0;
            interval    <= '0;
            phase_mid   <= 1'b0;
            shift_reg   <= '0;
            bit_pos     <= '0;
            byte_idx    <= '0;
            commit_pend <= 1'b0;
            frame_valid <= 1'b0;
            start_q     <= 1'b0;
            strobe_q    <= 1'b0;
            bit_q       <= 1'b0;
            error_q     <= 1'b0;
            for (int i = 0; i < FRAME_BYTES; i++) begin
                shadow[i]    <= '0;
                committed[i] <= '0;
            end
        end else if (enable) begin
            sync_p0 <= serial_in;
            sync_p1 <= sync_p0;
            line_p2 <= sync_p1;

            if (edge_seen)              interval <= CNT_W'(1);
            else if (interval != SAT_VAL) interval <= interval + CNT_W'(1);

            // The first edge out of IDLE is assumed to be a mid-bit edge
            if (edge_seen) begin
                if ((state == IDLE) || mid_edge) phase_mid <= 1'b1;
                else if (bound_edge)             phase_mid <= 1'b0;
            end

            if (clear_shift)     shift_reg <= '0;
            else if (take_shift) shift_reg <= shifted;

            if (do_lock) begin
                bit_pos  <= '0;
                byte_idx <= '0;
            end else if (take_bit) begin
                shadow[byte_idx][3'd7 - bit_pos] <= sync_p1;
                bit_pos <= bit_pos + 3'd1;
                if (bit_pos == 3'd7) byte_idx <= byte_idx + ADDR_W'(1);
            end

            // Whole-buffer copy one cycle after the last bit keeps frames untorn
            commit_pend <= take_bit && last_bit;
            if (commit_pend) begin
                committed   <= shadow;
                frame_valid <= 1'b1;
            end

            start_q  <= do_lock;
            strobe_q <= take_bit;
            error_q  <= do_abort;
            if (take_bit) bit_q <= sync_p1;
        end else begin
            start_q  <= 1'b0;
            strobe_q <= 1'b0;
            error_q  <= 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            read_data <= 8'h00;
        end else begin
            read_data <= (int'(address) < FRAME_BYTES) ? committed[address] : 8'h00;
        end
    end

    assign frame_start = start_q & enable;
    assign bit_strobe  = strobe_q & enable;
    assign error       = error_q & enable;
    assign bit_data    = bit_q;

endmodule

// File: tb/tb_manchester_frame_rx.sv
// Directed bench for manchester_frame_rx: Manchester transmitter model plus
// pulse counters, checked against hand-computed frame contents.
module tb_manchester_frame_rx;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       serial_in;
    logic [1:0] address;
    logic [7:0] read_data;
    logic       frame_valid, frame_start, bit_strobe, bit_data, error;

    int n_checks = 0;
    int n_errors = 0;

    int          n_start = 0;
    int          n_strobe = 0;
    int          n_err = 0;
    logic [31:0] rx_bits = '0;

    logic [7:0] tx_bytes [5];
    int         per_a = 16;
    int         per_b = 16;

    manchester_frame_rx dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .serial_in   (serial_in),
        .address     (address),
        .read_data   (read_data),
        .frame_valid (frame_valid),
        .frame_start (frame_start),
        .bit_strobe  (bit_strobe),
        .bit_data    (bit_data),
        .error       (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!reset) begin
            if (frame_start) n_start++;
            if (error)       n_err++;
            if (bit_strobe) begin
                n_strobe++;
                rx_bits = {rx_bits[30:0], bit_data};
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rd_chk(input logic [1:0] a, input logic [7:0] exp, input string tag);
        address = a;
        @(negedge clock);
        chk(tag, {24'h0, read_data}, {24'h0, exp});
    endtask

    task automatic set_frame(input logic [7:0] b0, b1, b2, b3, b4);
        tx_bytes[0] = b0; tx_bytes[1] = b1; tx_bytes[2] = b2;
        tx_bytes[3] = b3; tx_bytes[4] = b4;
    endtask

    task automatic idle_line(input logic lvl, input int cycles);
        serial_in = lvl;
        repeat (cycles) @(negedge clock);
    endtask

    task automatic send_bit(input logic b, input int period, input bit glitch, input bit pause);
        int h1, h2, s0, s1, s2;
        h1 = period / 2;
        h2 = period - h1;
        serial_in = ~b;
        if (glitch) begin
            repeat (3) @(negedge clock);
            serial_in = b;
            repeat (2) @(negedge clock);
            serial_in = ~b;
            repeat (h1 - 5) @(negedge clock);
        end else if (pause) begin
            repeat (4) @(negedge clock);
            s0 = n_strobe; s1 = n_start; s2 = n_err;
            enable = 1'b0;
            repeat (50) @(negedge clock);
            chk("pulses_while_disabled", n_strobe + n_start + n_err, s0 + s1 + s2);
            enable = 1'b1;
            repeat (h1 - 4) @(negedge clock);
        end else begin
            repeat (h1) @(negedge clock);
        end
        serial_in = b;
        repeat (h2) @(negedge clock);
    endtask

    // glitch_at / stop_at / pause_at are bit indices over the whole frame (-1 = unused)
    task automatic send_frame(input int glitch_at, input int stop_at, input int pause_at);
        int k;
        k = 0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 7; j >= 0; j--) begin
                if (k == stop_at) begin
                    repeat (40) @(negedge clock);
                    return;
                end
                send_bit(tx_bytes[i][j], (k % 2 == 1) ? per_b : per_a,
                         k == glitch_at, k == pause_at);
                k++;
            end
        end
        repeat (10) @(negedge clock);
    endtask

    task automatic check_buffer(input logic [31:0] exp, input string tag);
        rd_chk(2'd0, exp[31:24], {tag, "_b0"});
        rd_chk(2'd1, exp[23:16], {tag, "_b1"});
        rd_chk(2'd2, exp[15:8],  {tag, "_b2"});
        rd_chk(2'd3, exp[7:0],   {tag, "_b3"});
    endtask

    task automatic good_frame(input logic [31:0] payload, input string tag, input int pause_at);
        int s0, s1, s2;
        s0 = n_start; s1 = n_strobe; s2 = n_err;
        idle_line(1'b0, 40);
        set_frame(8'hAA, payload[31:24], payload[23:16], payload[15:8], payload[7:0]);
        send_frame(-1, -1, pause_at);
        chk({tag, "_starts"},  n_start - s0, 1);
        chk({tag, "_strobes"}, n_strobe - s1, 32);
        chk({tag, "_errors"},  n_err - s2, 0);
        chk({tag, "_bits"},    rx_bits, payload);
        chk({tag, "_valid"},   frame_valid, 1);
        check_buffer(payload, tag);
    endtask

    initial begin
        int s0, s1, s2;
        reset     = 1'b1;
        enable    = 1'b1;
        serial_in = 1'b0;
        address   = 2'd0;
        repeat (2) @(negedge clock);

        chk("rst_frame_valid", frame_valid, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_bit_strobe",  bit_strobe, 0);
        chk("rst_bit_data",    bit_data, 0);
        chk("rst_error",       error, 0);
        chk("rst_read_data",   read_data, 0);
        reset = 1'b0;
        check_buffer(32'h0, "rst");

        // Noise: three edges at random spacings, then quiet long enough to time out
        idle_line(1'b1, 40);
        serial_in = 1'b0;
        repeat ($urandom_range(2, 20)) @(negedge clock);
        serial_in = 1'b1;
        repeat ($urandom_range(2, 20)) @(negedge clock);
        serial_in = 1'b0;
        repeat (40) @(negedge clock);
        chk("noise_no_lock", n_start, 0);
        good_frame(32'h12345678, "noise", -1);

        good_frame(32'hDEADBEEF, "deadbeef", -1);

        // Glitch inside payload byte 2 (0x33), bit 3
        s0 = n_start; s1 = n_strobe; s2 = n_err;
        idle_line(1'b0, 40);
        set_frame(8'hAA, 8'h11, 8'h22, 8'h33, 8'h44);
        send_frame(27, -1, -1);
        idle_line(1'b0, 40);
        chk("glitch_starts",  n_start - s0, 1);
        chk("glitch_strobes", n_strobe - s1, 19);
        chk("glitch_errors",  n_err - s2, 1);
        chk("glitch_valid",   frame_valid, 1);
        check_buffer(32'hDEADBEEF, "glitch");

        // Line goes quiet after 12 payload bits
        s0 = n_start; s2 = n_err;
        idle_line(1'b0, 40);
        send_frame(-1, 20, -1);
        chk("timeout_starts", n_start - s0, 1);
        chk("timeout_errors", n_err - s2, 1);
        chk("timeout_valid",  frame_valid, 1);
        check_buffer(32'hDEADBEEF, "timeout");

        // Skewed bit periods plus an enable freeze in the middle of the payload
        per_a = 13;
        per_b = 19;
        good_frame(32'h5AC30FF0, "tolerance", 18);
        per_a = 16;
        per_b = 16;

        // Reset mid-frame clears the committed buffer and frame_valid
        idle_line(1'b0, 40);
        set_frame(8'hAA, 8'h11, 8'h22, 8'h33, 8'h44);
        send_frame(-1, 14, -1);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        chk("reset_mid_valid", frame_valid, 0);
        check_buffer(32'h0, "reset_mid");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
